// File: rtl/lt24_pkg.sv
// Shared LT24/ILI9341 command codes, decoder states and default panel geometry.
package lt24_pkg;

  localparam int LT24_WIDTH  = 240;
  localparam int LT24_HEIGHT = 320;

  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;
  localparam logic [7:0] CMD_SWRESET = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    OTHER
  } lt24_state_t;

endpackage

// File: rtl/lt24_bus_responder_if.sv
// LT24 write bus as seen by the responder, plus its framebuffer/status outputs.
interface lt24_bus_responder_if #(
  parameter int ADDR_W = 17
);
  logic              lt24_cs_n;
  logic              lt24_wr_n;
  logic              lt24_rs;
  logic [15:0]       lt24_d;
  logic              lt24_reset_n;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_wdata;
  logic              fb_we;
  logic              frame_done;
  logic [7:0]        cur_cmd;

  modport master (
    output lt24_cs_n, lt24_wr_n, lt24_rs, lt24_d, lt24_reset_n,
    input  fb_addr, fb_wdata, fb_we, frame_done, cur_cmd
  );

  modport slave (
    input  lt24_cs_n, lt24_wr_n, lt24_rs, lt24_d, lt24_reset_n,
    output fb_addr, fb_wdata, fb_we, frame_done, cur_cmd
  );
endinterface

// File: rtl/lt24_wr_event.sv
// Turns the falling edge of (cs_n|wr_n) into a single-cycle write event; rs/d pass through
// combinationally in the event cycle. No backpressure: the bus master owns the pace.
module lt24_wr_event (
  input  logic        clk,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        rs,
  input  logic [15:0] d,
  output logic        ev,
  output logic        ev_rs,
  output logic [15:0] ev_d
);

  // Pure strobe history; a reset does not need to clear it.
  logic idle_q;

  always_ff @(posedge clk) begin
    idle_q <= cs_n | wr_n;
  end

  assign ev    = ~cs_n & ~wr_n & idle_q;
  assign ev_rs = rs;
  assign ev_d  = d;

endmodule

// File: rtl/lt24_bus_responder.sv
// ILI9341 write-side emulator: decodes window commands and streams pixels to a framebuffer port.
// Pixel writes appear one cycle after the bus event; sustains one event every two clocks.
module lt24_bus_responder
  import lt24_pkg::*;
#(
  parameter int WIDTH  = LT24_WIDTH,
  parameter int HEIGHT = LT24_HEIGHT,
  parameter int ADDR_W = 17
) (
  input logic                 clk,
  input logic                 rst,
  lt24_bus_responder_if.slave bus
);

  localparam logic [15:0] W_LIM = 16'(WIDTH);
  localparam logic [15:0] H_LIM = 16'(HEIGHT);
  localparam logic [15:0] W_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] H_MAX = 16'(HEIGHT - 1);

  logic        ev;
  logic        ev_rs;
  logic [15:0] ev_d;

  lt24_wr_event u_wr_event (
    .clk  (clk),
    .cs_n (bus.lt24_cs_n),
    .wr_n (bus.lt24_wr_n),
    .rs   (bus.lt24_rs),
    .d    (bus.lt24_d),
    .ev   (ev),
    .ev_rs(ev_rs),
    .ev_d (ev_d)
  );

  logic              bus_rst;
  lt24_state_t       state_q, state_d;
  logic [15:0]       sc_q, ec_q, sp_q, ep_q, x_q, y_q;
  logic [2:0]        pcnt_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [15:0]       fb_wdata_q;
  logic              fb_we_q, frame_done_q;
  logic [7:0]        cur_cmd_q;
  logic              cmd_ev, dat_ev, in_range, wrap_x, wrap_y;
  logic [ADDR_W-1:0] lin_addr;

  assign bus_rst  = rst | ~bus.lt24_reset_n;
  assign cmd_ev   = ev & ~ev_rs;
  assign dat_ev   = ev & ev_rs;
  assign in_range = (x_q < W_LIM) && (y_q < H_LIM);
  assign wrap_x   = (x_q >= ec_q);
  assign wrap_y   = (y_q >= ep_q);
  assign lin_addr = ADDR_W'(32'(y_q) * 32'(WIDTH) + 32'(x_q));

  always_ff @(posedge clk) begin
    if (bus_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cmd_ev) begin
      unique case (ev_d[7:0])
        CMD_CASET:              state_d = CASET;
        CMD_PASET:              state_d = PASET;
        CMD_RAMWR, CMD_RAMWRC:  state_d = RAMWR;
        CMD_SWRESET:            state_d = IDLE;
        default:                state_d = OTHER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus_rst) begin
      sc_q <= '0; ec_q <= W_MAX; sp_q <= '0; ep_q <= H_MAX;
      x_q <= '0; y_q <= '0; pcnt_q <= '0;
      fb_we_q <= 1'b0; frame_done_q <= 1'b0;
      fb_addr_q <= '0; fb_wdata_q <= '0; cur_cmd_q <= '0;
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (cmd_ev) begin
        cur_cmd_q <= ev_d[7:0];
        pcnt_q    <= '0;
        if (ev_d[7:0] == CMD_RAMWR) begin
          x_q <= sc_q;
          y_q <= sp_q;
        end else if (ev_d[7:0] == CMD_SWRESET) begin
          sc_q <= '0; ec_q <= W_MAX; sp_q <= '0; ep_q <= H_MAX;
          x_q <= '0; y_q <= '0;
        end
      end else if (dat_ev) begin
        unique case (state_q)
          CASET, PASET: begin
            // Each parameter byte lands immediately; a short list only touches its bytes.
            if (!pcnt_q[2]) begin
              pcnt_q <= pcnt_q + 3'd1;
              if (state_q == CASET) begin
                unique case (pcnt_q[1:0])
                  2'd0: sc_q[15:8] <= ev_d[7:0];
                  2'd1: sc_q[7:0]  <= ev_d[7:0];
                  2'd2: ec_q[15:8] <= ev_d[7:0];
                  2'd3: ec_q[7:0]  <= ev_d[7:0];
                endcase
              end else begin
                unique case (pcnt_q[1:0])
                  2'd0: sp_q[15:8] <= ev_d[7:0];
                  2'd1: sp_q[7:0]  <= ev_d[7:0];
                  2'd2: ep_q[15:8] <= ev_d[7:0];
                  2'd3: ep_q[7:0]  <= ev_d[7:0];
                endcase
              end
            end
          end
          RAMWR: begin
            fb_we_q      <= in_range;
            fb_wdata_q   <= ev_d;
            fb_addr_q    <= lin_addr;
            frame_done_q <= wrap_x & wrap_y;
            if (wrap_x) begin
              x_q <= sc_q;
              y_q <= wrap_y ? sp_q : y_q + 16'd1;
            end else begin
              x_q <= x_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.fb_we      = fb_we_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cur_cmd    = cur_cmd_q;

endmodule

// File: tb/tb_lt24_bus_responder.sv
// Bench for lt24_bus_responder: directed scenarios plus random traffic against a
// transaction-level model of the panel's window/cursor rules.
module tb_lt24_bus_responder;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lt24_bus_responder_if #(.ADDR_W(AW)) bus ();

  lt24_bus_responder #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit            vld;
    bit            we;
    bit            fd;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [7:0]    cmd;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    bit            fd;
  } wr_t;

  typedef enum {M_IDLE, M_CASET, M_PASET, M_PIX, M_OTHER} mode_t;

  exp_t        exp_pend, exp_cur;
  wr_t         log_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  mode_t       m_mode;
  logic [15:0] m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  int          m_pcnt;
  bit          m_prev_idle = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_window_reset();
    m_mode = M_IDLE;
    m_sc = 16'd0; m_ec = 16'(W - 1); m_sp = 16'd0; m_ep = 16'(H - 1);
    m_x = 16'd0; m_y = 16'd0; m_pcnt = 0;
  endfunction

  // What the DUT outputs must read one clock after this cycle's inputs.
  function automatic void model_step(input bit cs_n, input bit wr_n, input bit rs,
                                     input logic [15:0] d, input bit reset_n, input bit r);
    bit ev;
    bit inr;
    logic [15:0] v;
    int unsigned lin;
    ev = !cs_n && !wr_n && m_prev_idle;
    m_prev_idle = cs_n || wr_n;
    exp_pend.we = 1'b0;
    exp_pend.fd = 1'b0;
    if (r || !reset_n) begin
      model_window_reset();
      exp_pend.vld = 1'b1; exp_pend.addr = '0; exp_pend.wdata = '0; exp_pend.cmd = '0;
      return;
    end
    if (!ev) return;
    if (!rs) begin
      exp_pend.cmd = d[7:0];
      m_pcnt = 0;
      case (d[7:0])
        8'h2A: m_mode = M_CASET;
        8'h2B: m_mode = M_PASET;
        8'h2C: begin m_mode = M_PIX; m_x = m_sc; m_y = m_sp; end
        8'h3C: m_mode = M_PIX;
        8'h01: model_window_reset();
        default: m_mode = M_OTHER;
      endcase
    end else if (m_mode == M_CASET || m_mode == M_PASET) begin
      if (m_pcnt < 4) begin
        if (m_mode == M_CASET) v = (m_pcnt < 2) ? m_sc : m_ec;
        else                   v = (m_pcnt < 2) ? m_sp : m_ep;
        if (m_pcnt % 2 == 0) v[15:8] = d[7:0];
        else                 v[7:0]  = d[7:0];
        if (m_mode == M_CASET) begin if (m_pcnt < 2) m_sc = v; else m_ec = v; end
        else                   begin if (m_pcnt < 2) m_sp = v; else m_ep = v; end
        m_pcnt++;
      end
    end else if (m_mode == M_PIX) begin
      inr = (int'(m_x) < W) && (int'(m_y) < H);
      lin = int'(m_y) * W + int'(m_x);
      exp_pend.we    = inr;
      exp_pend.fd    = (m_x >= m_ec) && (m_y >= m_ep);
      exp_pend.addr  = AW'(lin % (1 << AW));
      exp_pend.wdata = d;
      if (m_x >= m_ec) begin
        m_x = m_sc;
        if (m_y >= m_ep) m_y = m_sp;
        else             m_y = m_y + 16'd1;
      end else begin
        m_x = m_x + 16'd1;
      end
    end
  endfunction

  task automatic tick(input bit cs_n, input bit wr_n, input bit rs, input logic [15:0] d,
                      input bit reset_n = 1'b1, input bit r = 1'b0);
    @(posedge clk);
    #1;
    exp_cur = exp_pend;
    bus.lt24_cs_n    = cs_n;
    bus.lt24_wr_n    = wr_n;
    bus.lt24_rs      = rs;
    bus.lt24_d       = d;
    bus.lt24_reset_n = reset_n;
    rst              = r;
    model_step(cs_n, wr_n, rs, d, reset_n, r);
  endtask

  task automatic bus_wr(input bit rs, input logic [15:0] d, input int width = 1, input int gap = 1);
    repeat (width) tick(1'b0, 1'b0, rs, d);
    repeat (gap)   tick(1'b0, 1'b1, rs, d);
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_wr(1'b0, {8'h00, c});
  endtask

  task automatic par(input logic [15:0] b);
    bus_wr(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (exp_cur.vld) begin
      check("fb_we",      32'(bus.fb_we),      32'(exp_cur.we));
      check("frame_done", 32'(bus.frame_done), 32'(exp_cur.fd));
      check("fb_addr",    32'(bus.fb_addr),    32'(exp_cur.addr));
      check("fb_wdata",   32'(bus.fb_wdata),   32'(exp_cur.wdata));
      check("cur_cmd",    32'(bus.cur_cmd),    32'(exp_cur.cmd));
      if (bus.fb_we || bus.frame_done)
        log_q.push_back('{addr: bus.fb_addr, data: bus.fb_wdata, fd: bus.frame_done});
    end
  end

  initial begin
    int fd_cnt;
    int exp_win[7];
    logic [7:0] cmds[6];
    exp_win = '{1210, 1211, 1212, 1450, 1451, 1452, 1210};
    cmds    = '{8'h2A, 8'h2B, 8'h2C, 8'h3C, 8'h01, 8'hB1};
    exp_pend = '{vld: 1'b0, we: 1'b0, fd: 1'b0, addr: '0, wdata: '0, cmd: '0};
    exp_cur  = exp_pend;
    bus.lt24_cs_n = 1'b1; bus.lt24_wr_n = 1'b1; bus.lt24_rs = 1'b0;
    bus.lt24_d = 16'h0; bus.lt24_reset_n = 1'b1;
    model_window_reset();

    repeat (3) tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    idle(2);
    check("reset_cur_cmd", 32'(bus.cur_cmd), 32'h0);
    check("reset_fb_addr", 32'(bus.fb_addr), 32'h0);

    // Full-window stream from the top-left corner.
    log_q.delete();
    cmd(8'h2A); par(16'h0); par(16'h0);
    cmd(8'h2B); par(16'h0); par(16'h0);
    cmd(8'h2C);
    for (int i = 0; i < 300; i++) par(16'(i));
    idle(2);
    check("stream_count", log_q.size(), 300);
    check("stream_px241_addr", 32'(log_q[241].addr), 241);
    check("stream_px241_data", 32'(log_q[241].data), 241);

    // Bottom four rows: the final pixel of the screen closes the frame, then wraps.
    log_q.delete();
    cmd(8'h2B); par(16'h01); par(16'h3C); par(16'h01); par(16'h3F);
    cmd(8'h2A); par(16'h00); par(16'h00); par(16'h00); par(16'hEF);
    cmd(8'h2C);
    for (int i = 0; i < 961; i++) par(16'(i));
    idle(2);
    fd_cnt = 0;
    foreach (log_q[i]) if (log_q[i].fd) fd_cnt++;
    check("tail_count", log_q.size(), 961);
    check("tail_frame_done_cnt", fd_cnt, 1);
    check("tail_last_fd", 32'(log_q[959].fd), 1);
    check("tail_last_addr", 32'(log_q[959].addr), 76799);
    check("tail_wrap_addr", 32'(log_q[960].addr), 75840);

    // Small window 10..12 x 5..6.
    cmd(8'h01);
    log_q.delete();
    cmd(8'h2A); par(16'h0); par(16'd10); par(16'h0); par(16'd12);
    cmd(8'h2B); par(16'h0); par(16'd5);  par(16'h0); par(16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) par(16'hA0 + 16'(i));
    idle(2);
    check("win_count", log_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("win_addr%0d", i), 32'(log_q[i].addr), exp_win[i]);
      check($sformatf("win_fd%0d", i), 32'(log_q[i].fd), (i == 5) ? 1 : 0);
    end

    // SWRESET after a custom window, then RAMWR-continue versus RAMWR.
    cmd(8'h01);
    log_q.delete();
    cmd(8'h2C);
    for (int i = 0; i < 3; i++) par(16'h100 + 16'(i));
    cmd(8'h3C); par(16'h200);
    cmd(8'h2C); par(16'h300);
    idle(2);
    check("cont_count", log_q.size(), 5);
    check("swreset_first_addr", 32'(log_q[0].addr), 0);
    check("cont_addr", 32'(log_q[3].addr), 3);
    check("restart_addr", 32'(log_q[4].addr), 0);

    // EC=256: columns 240..256 suppressed, next row starts at 240.
    cmd(8'h01);
    log_q.delete();
    cmd(8'h2A); par(16'h0); par(16'h0); par(16'h01); par(16'h00);
    cmd(8'h2C);
    for (int i = 0; i < 258; i++) par(16'(i));
    idle(2);
    check("oor_count", log_q.size(), 241);
    check("oor_row0_last", 32'(log_q[239].addr), 239);
    check("oor_row1_first", 32'(log_q[240].addr), 240);

    // SC > EC: every pixel lands in column 5.
    cmd(8'h01);
    log_q.delete();
    cmd(8'h2A); par(16'h0); par(16'd5); par(16'h0); par(16'd3);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) par(16'(i));
    idle(2);
    check("odd_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("odd_addr%0d", i), 32'(log_q[i].addr), 5 + 240 * i);

    // rst coinciding with a pixel event aborts RAMWR; window back to defaults.
    cmd(8'h01);
    cmd(8'h2A); par(16'h0); par(16'd10); par(16'h0); par(16'd12);
    log_q.delete();
    cmd(8'h2C); par(16'h1); par(16'h2);
    tick(1'b0, 1'b0, 1'b1, 16'h3, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 16'h3);
    par(16'h4); par(16'h5);
    idle(2);
    check("abort_rst_count", log_q.size(), 2);
    cmd(8'h2C);
    for (int i = 0; i < 241; i++) par(16'(i));
    idle(2);
    check("abort_rst_default_row", 32'(log_q[242].addr), 240);

    // Panel reset pin doing the same.
    log_q.delete();
    cmd(8'h2C); par(16'h7); par(16'h8);
    tick(1'b0, 1'b0, 1'b1, 16'h9, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 16'h9);
    par(16'hA);
    cmd(8'h3C); par(16'hB);
    idle(2);
    check("abort_pin_count", log_q.size(), 3);
    check("abort_pin_cursor", 32'(log_q[2].addr), 0);

    // Strobe discipline and an unknown command.
    cmd(8'h01);
    log_q.delete();
    cmd(8'h2C);
    bus_wr(1'b1, 16'h55, 5, 1);
    repeat (3) begin
      tick(1'b1, 1'b0, 1'b1, 16'h66);
      tick(1'b1, 1'b1, 1'b1, 16'h66);
    end
    idle(2);
    check("long_strobe_count", log_q.size(), 1);
    cmd(8'hB1); par(16'h11); par(16'h22); par(16'h33); par(16'h44);
    idle(2);
    check("unknown_cmd", 32'(bus.cur_cmd), 32'hB1);
    check("unknown_no_write", log_q.size(), 1);
    cmd(8'h3C); par(16'h77);
    idle(2);
    check("unknown_cursor_kept", 32'(log_q[1].addr), 1);

    // Random traffic; every cycle is compared against the model.
    for (int n = 0; n < 2500; n++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 12) begin
        if ($urandom_range(0, 5) == 0) cmd(8'($urandom));
        else cmd(cmds[$urandom_range(0, 5)]);
      end else if (k < 15) begin
        tick(1'b1, 1'b0, 1'($urandom), 16'($urandom));
        tick(1'b1, 1'b1, 1'b0, 16'h0);
      end else if (k == 15) begin
        tick(1'b0, 1'b0, 1'($urandom), 16'($urandom), 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 16'h0);
      end else begin
        bus_wr(1'b1,
               ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom),
               $urandom_range(1, 3), $urandom_range(1, 2));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lt24_bus_responder.md
Name: lt24_bus_responder

Overview:
- Responder end of the LT24 8080-style write bus: the same bus the screen-driving blocks and the CPU master.
- Decodes ILI9341 command/parameter writes (CASET 0x2A, PASET 0x2B, RAMWR 0x2C, RAMWR-continue 0x3C, SWRESET 0x01).
- Tracks the address window and cursor, and streams received pixels into an on-chip framebuffer port.
- Used as an LCD emulator/frame grabber: it mirrors screen contents for readback and lets the team verify bus masters without the panel.

Parameters:
- WIDTH, 240, columns (x range 0..WIDTH-1)
- HEIGHT, 320, rows (y range 0..HEIGHT-1)
- ADDR_W, 17, framebuffer address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lt24_cs_n  in  1  bus chip select, active low, synchronous to clk
- lt24_wr_n  in  1  bus write strobe, active low
- lt24_rs  in  1  0 = command, 1 = data/parameter
- lt24_d  in  16  bus data
- lt24_reset_n  in  1  panel reset, active low
- fb_addr  out  ADDR_W  framebuffer write address = y*WIDTH + x
- fb_wdata  out  16  RGB565 pixel
- fb_we  out  1  framebuffer write enable, one-cycle pulse per pixel
- frame_done  out  1  one-cycle pulse when the last pixel of the window (x=EC, y=EP) is written
- cur_cmd  out  8  last command byte accepted (status)

Behaviour:
- Bus write event (ev): a cycle with cs_n=0 and wr_n=0 whose previous cycle had (cs_n|wr_n)=1.
  - rs and d are sampled in the ev cycle.
  - A sustained low pulse counts as exactly one event.
- Reset: rst=1, or lt24_reset_n=0 (sampled synchronously), sets:
  - state=IDLE, SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1, x=0, y=0, param_cnt=0
  - fb_we=0, frame_done=0, fb_addr=0, fb_wdata=0, cur_cmd=0x00
  - Reset has priority over any event in the same cycle; an aborted RAMWR writes nothing further.
- Command event (rs=0): cur_cmd<=d[7:0] and param_cnt<=0. Next state:
  - 0x2A -> CASET
  - 0x2B -> PASET
  - 0x2C -> RAMWR, with x<=SC, y<=SP
  - 0x3C -> RAMWR, cursor unchanged
  - 0x01 -> IDLE, window and cursor restored to reset values
  - any other code -> OTHER (its parameters are ignored)
  - A command arriving in any state terminates the current state immediately.
- CASET/PASET parameter events (rs=1): param_cnt indexes 0..3 and loads, in order:
  - 0 -> start[15:8]
  - 1 -> start[7:0]
  - 2 -> end[15:8]
  - 3 -> end[7:0]
  - Byte taken from d[7:0] (CASET writes SC/EC, PASET writes SP/EP).
  - Each byte updates its register immediately, so a partial list (e.g. only 2 params) updates only those bytes.
  - Parameters beyond the 4th are ignored.
- RAMWR pixel event (rs=1):
  - Latency 1: the cycle after ev, fb_we=1, fb_wdata=d, fb_addr=y*WIDTH+x, all registered.
  - Write suppressed (fb_we=0) when x>=WIDTH or y>=HEIGHT; the cursor still advances.
  - Cursor advance:
    - if x>=EC: x<=SC, and then if y>=EP, y<=SP, otherwise y<=y+1
    - else x<=x+1
  - frame_done pulses together with the fb_we of the pixel written at x>=EC and y>=EP, i.e. the window wrap. It pulses even if that write was suppressed.
- Data events in IDLE or OTHER: ignored.
- SC>EC or SP>SR are legal: the >= compares make every pixel wrap immediately on that axis; no lockup.
- Arithmetic: x, y, SC, EC, SP, EP are 16 bits. The address product is truncated to ADDR_W.
  - Implementation may keep an incremental row base instead of a multiplier, provided the latency stays 1.
- Event rate: back-to-back events every 2 clk must be sustained with no loss.

Decomposition:
- Package lt24_pkg:
  - command constants: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, CMD_RAMWRC=8'h3C, CMD_SWRESET=8'h01
  - state enum: IDLE, CASET, PASET, RAMWR, OTHER
  - default WIDTH/HEIGHT
- One sub-module, lt24_wr_event: strobe edge detector producing ev, ev_rs, ev_d. Everything else lives in the top.

Test Plan:
- Full-screen stream:
  - Stimulus: 0x2A,0,0,0x2B,0,0,0x2C, then 76800 pixels valued (index mod 65536).
  - Required: fb_we count 76800; pixel 241 at fb_addr 241.
  - Required: frame_done exactly once, on the last pixel.
  - Required: a 76801st pixel lands at addr 0.
- Window:
  - Stimulus: CASET 0,10,0,12; PASET 0,5,0,6; RAMWR; 7 pixels A..G.
  - Required addresses: 1210, 1211, 1212, 1450, 1451, 1452, then G at 1210.
  - Required: frame_done with F.
- RAMWR continue:
  - Stimulus: after 3 pixels of a default-window RAMWR, send 0x3C plus 1 pixel.
  - Required: that pixel writes addr 3.
  - Stimulus: then 0x2C plus 1 pixel. Required: writes addr 0.
- Out-of-range and odd windows:
  - Stimulus: CASET 0,0,0x01,0x00 (EC=256).
  - Required: pixels at x 240..255 give fb_we=0; x wraps to 0 after x=256; next row base is 240.
  - Stimulus: SC=5, EC=3. Required: every pixel writes column 5.
- Reset and abort:
  - Stimulus: rst, or lt24_reset_n=0, asserted mid-RAMWR in the same cycle as an ev.
  - Required: no fb_we follows; window returns to defaults.
  - Stimulus: 0x01 after a custom CASET. Required: the next RAMWR starts at addr 0.
- Strobe discipline:
  - Stimulus: wr_n held low 5 cycles with cs_n low. Required: exactly one pixel.
  - Stimulus: wr_n pulses with cs_n=1. Required: no effect.
  - Stimulus: unknown command 0xB1 then 3 params. Required: no state change.
